// File: rtl/turn_sequencer_np.sv
// Purpose : N-player board-game turn sequencer with internal move legality checking.
// Latency : move sampled at edge t -> place_strb in cycle t+1 -> win_in sampled at edge t+1+CHECK_CYCLES.
// Backpressure: none; moves are only accepted in WAIT, other requests pulse illegal/out_of_turn or are ignored.
//
// Ports:
//   clk, reset (async, active-high), new_game (sync clear)
//   move_valid[NUM_PLAYERS], move_pos[POS_W]   : per-player request, shared 1-based cell index
//   win_in[NUM_PLAYERS]                        : external win detector result per player
//   cur_player, place_strb, place_owner        : turn owner and one-cycle placement strobe
//   board_occ, illegal, out_of_turn            : occupancy map and rejection pulses
//   game_over, winner, tie                     : end-of-game status levels
module turn_sequencer_np #(
    parameter  int NUM_PLAYERS  = 2,
    parameter  int CELLS        = 9,
    parameter  int POS_W        = 4,
    parameter  int CHECK_CYCLES = 2,
    localparam int PW           = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_game,
    input  logic [NUM_PLAYERS-1:0] move_valid,
    input  logic [POS_W-1:0]       move_pos,
    input  logic [NUM_PLAYERS-1:0] win_in,
    output logic [PW-1:0]          cur_player,
    output logic [CELLS-1:0]       place_strb,
    output logic [PW-1:0]          place_owner,
    output logic [CELLS-1:0]       board_occ,
    output logic                   illegal,
    output logic                   out_of_turn,
    output logic                   game_over,
    output logic [PW:0]            winner,
    output logic                   tie
);

    // Counter only needs to hold CHECK_CYCLES-1.
    localparam int CW = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;

    typedef enum logic [1:0] {S_WAIT, S_PLACE, S_CHECK, S_OVER} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_cur_player;
    logic [CELLS-1:0] r_place_strb;
    logic [PW-1:0]    r_place_owner;
    logic [CELLS-1:0] r_board_occ;
    logic             r_illegal;
    logic             r_out_of_turn;
    logic             r_game_over;
    logic [PW:0]      r_winner;
    logic             r_tie;
    logic [CW-1:0]    r_cnt;

    logic [CELLS-1:0]       w_pos_hot;
    logic [NUM_PLAYERS-1:0] w_cur_hot;
    logic                   w_cur_req;
    logic                   w_other_req;
    logic                   w_legal;
    logic                   w_cur_win;
    logic [PW-1:0]          w_next_player;

    // Decoding the position to one-hot doubles as the range check:
    // positions 0 and >CELLS decode to all zeros.
    always_comb begin
        w_pos_hot = '0;
        for (int i = 0; i < CELLS; i++) begin
            w_pos_hot[i] = (move_pos == POS_W'(i + 1));
        end
    end

    always_comb begin
        w_cur_hot = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_cur_hot[i] = (r_cur_player == PW'(i));
        end
    end

    assign w_cur_req     = |(move_valid & w_cur_hot);
    assign w_other_req   = |(move_valid & ~w_cur_hot);
    assign w_legal       = (|w_pos_hot) && !(|(w_pos_hot & r_board_occ));
    assign w_cur_win     = |(win_in & w_cur_hot);
    assign w_next_player = (r_cur_player == PW'(NUM_PLAYERS - 1)) ? '0 : r_cur_player + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_WAIT;
            r_cur_player  <= '0;
            r_place_strb  <= '0;
            r_place_owner <= '0;
            r_board_occ   <= '0;
            r_illegal     <= 1'b0;
            r_out_of_turn <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner      <= '0;
            r_tie         <= 1'b0;
            r_cnt         <= '0;
        end else if (new_game) begin
            // Abandons any pending check; nothing from it is recorded.
            r_state       <= S_WAIT;
            r_cur_player  <= '0;
            r_place_strb  <= '0;
            r_place_owner <= '0;
            r_board_occ   <= '0;
            r_illegal     <= 1'b0;
            r_out_of_turn <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner      <= '0;
            r_tie         <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_illegal     <= 1'b0;
            r_out_of_turn <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    r_out_of_turn <= w_other_req;
                    if (w_cur_req) begin
                        if (w_legal) begin
                            r_place_strb  <= w_pos_hot;
                            r_place_owner <= r_cur_player;
                            r_state       <= S_PLACE;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_PLACE: begin
                    r_board_occ   <= r_board_occ | r_place_strb;
                    r_place_strb  <= '0;
                    r_place_owner <= '0;
                    r_cnt         <= CW'(CHECK_CYCLES - 1);
                    r_state       <= S_CHECK;
                end
                S_CHECK: begin
                    // win_in is only trusted once the detector latency has elapsed.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_cur_win) begin
                        r_game_over <= 1'b1;
                        r_winner    <= (PW + 1)'(r_cur_player) + (PW + 1)'(1);
                        r_state     <= S_OVER;
                    end else if (&r_board_occ) begin
                        r_game_over <= 1'b1;
                        r_tie       <= 1'b1;
                        r_winner    <= '0;
                        r_state     <= S_OVER;
                    end else begin
                        r_cur_player <= w_next_player;
                        r_state      <= S_WAIT;
                    end
                end
                S_OVER: begin
                    // Hold everything until new_game or reset.
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign cur_player  = r_cur_player;
    assign place_strb  = r_place_strb;
    assign place_owner = r_place_owner;
    assign board_occ   = r_board_occ;
    assign illegal     = r_illegal;
    assign out_of_turn = r_out_of_turn;
    assign game_over   = r_game_over;
    assign winner      = r_winner;
    assign tie         = r_tie;

endmodule

// File: tb/tb_turn_sequencer_np.sv
module tb_turn_sequencer_np;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUT A: default parameters ----------------
    localparam int CC_A = 2;
    logic       rst_a, ng_a;
    logic [1:0] mv_a, win_a;
    logic [3:0] pos_a;
    logic [0:0] cur_a, own_a;
    logic [8:0] strb_a, occ_a;
    logic       ill_a, oot_a, go_a, tie_a;
    logic [1:0] winr_a;

    turn_sequencer_np dut_a (
        .clk(clk), .reset(rst_a), .new_game(ng_a), .move_valid(mv_a), .move_pos(pos_a),
        .win_in(win_a), .cur_player(cur_a), .place_strb(strb_a), .place_owner(own_a),
        .board_occ(occ_a), .illegal(ill_a), .out_of_turn(oot_a), .game_over(go_a),
        .winner(winr_a), .tie(tie_a)
    );

    // ---------------- DUT B: 3 players, 16 cells ----------------
    localparam int CC_B = 4;
    logic        rst_b, ng_b;
    logic [2:0]  mv_b, win_b;
    logic [4:0]  pos_b;
    logic [1:0]  cur_b, own_b;
    logic [15:0] strb_b, occ_b;
    logic        ill_b, oot_b, go_b, tie_b;
    logic [2:0]  winr_b;

    turn_sequencer_np #(.NUM_PLAYERS(3), .CELLS(16), .POS_W(5), .CHECK_CYCLES(CC_B)) dut_b (
        .clk(clk), .reset(rst_b), .new_game(ng_b), .move_valid(mv_b), .move_pos(pos_b),
        .win_in(win_b), .cur_player(cur_b), .place_strb(strb_b), .place_owner(own_b),
        .board_occ(occ_b), .illegal(ill_b), .out_of_turn(oot_b), .game_over(go_b),
        .winner(winr_b), .tie(tie_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic play_a(input int p, input int pos, input logic [1:0] win);
        mv_a = 2'(1 << p); pos_a = 4'(pos); win_a = win;
        step();
        mv_a = '0;
        chk("a_strb", 32'(strb_a), 32'(1 << (pos - 1)));
        chk("a_owner", 32'(own_a), 32'(p));
        repeat (CC_A + 1) step();
        win_a = '0;
    endtask

    task automatic play_b(input int p, input int pos, input logic [2:0] win);
        mv_b = 3'(1 << p); pos_b = 5'(pos); win_b = win;
        step();
        mv_b = '0;
        chk("b_strb", 32'(strb_b), 32'(1 << (pos - 1)));
        repeat (CC_B + 1) step();
        win_b = '0;
    endtask

    task automatic new_game_a();
        ng_a = 1'b1;
        step();
        ng_a = 1'b0;
        chk("a_ng_occ", 32'(occ_a), 32'h0);
        chk("a_ng_cur", 32'(cur_a), 32'h0);
    endtask

    initial begin
        rst_a = 1'b1; ng_a = 1'b0; mv_a = '0; pos_a = '0; win_a = '0;
        rst_b = 1'b1; ng_b = 1'b0; mv_b = '0; pos_b = '0; win_b = '0;
        #12;
        chk("rst_cur", 32'(cur_a), 0);
        chk("rst_occ", 32'(occ_a), 0);
        chk("rst_strb", 32'(strb_a), 0);
        chk("rst_go", 32'(go_a), 0);
        chk("rst_winner", 32'(winr_a), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        step();

        // 1: two legal moves, timing of the turn hand-over
        mv_a = 2'b01; pos_a = 4'd5;
        step();
        mv_a = '0;
        chk("t1_strb0", 32'(strb_a), 32'h010);
        step();
        chk("t1_strb_off", 32'(strb_a), 32'h0);
        chk("t1_occ", 32'(occ_a), 32'h010);
        step();
        chk("t1_cur_hold", 32'(cur_a), 0);
        step();
        chk("t1_cur1", 32'(cur_a), 1);
        play_a(1, 1, 2'b00);
        chk("t1_cur0", 32'(cur_a), 0);
        chk("t1_occ2", 32'(occ_a), 32'h011);

        // 2: occupied cell is illegal
        new_game_a();
        play_a(0, 5, 2'b00);
        mv_a = 2'b10; pos_a = 4'd5;
        step();
        mv_a = '0;
        chk("t2_illegal", 32'(ill_a), 1);
        chk("t2_nostrb", 32'(strb_a), 0);
        step();
        chk("t2_ill_pulse", 32'(ill_a), 0);
        chk("t2_occ", 32'(occ_a), 32'h010);
        chk("t2_cur", 32'(cur_a), 1);

        // 3: out-of-range positions and out-of-turn requests
        new_game_a();
        mv_a = 2'b01; pos_a = 4'd0;
        step();
        chk("t3_pos0", 32'(ill_a), 1);
        pos_a = 4'd10;
        step();
        chk("t3_pos10", 32'(ill_a), 1);
        mv_a = 2'b10; pos_a = 4'd3;
        step();
        mv_a = '0;
        chk("t3_oot", 32'(oot_a), 1);
        chk("t3_oot_ill", 32'(ill_a), 0);
        chk("t3_oot_strb", 32'(strb_a), 0);
        step();
        chk("t3_oot_pulse", 32'(oot_a), 0);
        chk("t3_occ", 32'(occ_a), 0);

        // 4: P0 wins with 1,2,3; another player's win bit is ignored
        new_game_a();
        play_a(0, 1, 2'b00);
        play_a(1, 4, 2'b01);
        chk("t4_other_win", 32'(go_a), 0);
        play_a(0, 2, 2'b00);
        play_a(1, 5, 2'b00);
        play_a(0, 3, 2'b01);
        chk("t4_go", 32'(go_a), 1);
        chk("t4_winner", 32'(winr_a), 1);
        chk("t4_tie", 32'(tie_a), 0);
        mv_a = 2'b01; pos_a = 4'd7;
        step();
        mv_a = 2'b10;
        step();
        mv_a = '0;
        chk("t4_over_ill", 32'(ill_a), 0);
        chk("t4_over_oot", 32'(oot_a), 0);
        chk("t4_over_strb", 32'(strb_a), 0);
        chk("t4_over_occ", 32'(occ_a), 32'h01F);
        step();
        chk("t4_over_hold", 32'(go_a), 1);
        new_game_a();
        chk("t4_ng_go", 32'(go_a), 0);
        chk("t4_ng_winner", 32'(winr_a), 0);

        // 5: full board with no winner -> tie
        new_game_a();
        for (int i = 1; i <= 8; i++) play_a((i - 1) % 2, i, 2'b00);
        chk("t5_go_early", 32'(go_a), 0);
        play_a(0, 9, 2'b00);
        chk("t5_go", 32'(go_a), 1);
        chk("t5_tie", 32'(tie_a), 1);
        chk("t5_winner", 32'(winr_a), 0);
        chk("t5_occ", 32'(occ_a), 32'h1FF);

        // 6: three players, longer check window
        chk("t6_cur0", 32'(cur_b), 0);
        play_b(0, 1, 3'b000);
        chk("t6_cur1", 32'(cur_b), 1);
        play_b(1, 2, 3'b100);
        chk("t6_cur2", 32'(cur_b), 2);
        chk("t6_no_win", 32'(go_b), 0);
        play_b(2, 16, 3'b000);
        chk("t6_wrap", 32'(cur_b), 0);
        chk("t6_occ", 32'(occ_b), 32'h8003);
        mv_b = 3'b001; pos_b = 5'd8; win_b = 3'b001;
        step();
        mv_b = '0;
        step();
        step();
        rst_b = 1'b1;
        #1;
        chk("t6_rst_occ", 32'(occ_b), 0);
        chk("t6_rst_strb", 32'(strb_b), 0);
        step();
        rst_b = 1'b0;
        repeat (CC_B + 2) step();
        win_b = '0;
        chk("t6_rst_cur", 32'(cur_b), 0);
        chk("t6_rst_go", 32'(go_b), 0);
        chk("t6_rst_winner", 32'(winr_b), 0);
        chk("t6_rst_occ2", 32'(occ_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
